// File: rtl/axis_to_qfifo.sv
// AXI4-Stream packet to queue-tagged first-word-fall-through FIFO.
// Optional TUSER header word per packet; invalid destinations are dropped and counted.
module axis_to_qfifo #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES           = 4,
  parameter int NUM_QUEUES_BITS      = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
  parameter int DST_PORT_POS         = 24,
  parameter int DEPTH_BITS           = 4,
  parameter int HDR_EN               = 1
) (
  input  logic                                 axi_aclk,
  input  logic                                 axi_areset,
  input  logic                                 sw_rst,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic                                 s_axis_tlast,
  input  logic                                 fifo_rd_en,
  output logic [C_S_AXIS_DATA_WIDTH*9/8-1:0]   fifo_dout,
  output logic [NUM_QUEUES_BITS-1:0]           fifo_dout_qid,
  output logic                                 fifo_dout_sof,
  output logic                                 fifo_dout_eof,
  output logic                                 fifo_empty,
  output logic [DEPTH_BITS:0]                  fifo_count,
  output logic [31:0]                          drop_cnt,
  output logic [31:0]                          pkt_cnt
);

  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int NB    = DW / 8;
  localparam int FW    = NB * 9;
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int EW    = FW + NUM_QUEUES_BITS + 2;

  localparam logic [DEPTH_BITS:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_BITS:0]   CNT_FULL = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {S_HDR, S_PKT, S_DROP} state_t;

  state_t                     state_q, state_nxt;
  logic [NUM_QUEUES-1:0]      dv;
  logic                       dst_ok;
  logic [NUM_QUEUES_BITS-1:0] qid_dec, qid_q;
  logic [DW-1:0]              tuser_ext;
  logic [FW-1:0]              data_word, hdr_word;

  logic                       tready_c;
  logic                       wr_en, wr_sof, wr_eof, qid_ld, pkt_inc, drop_inc;
  logic [FW-1:0]              wr_data;
  logic [NUM_QUEUES_BITS-1:0] wr_qid;

  logic [EW-1:0]              mem [0:DEPTH-1];
  logic [DEPTH_BITS-1:0]      wr_ptr, rd_ptr;
  logic [DEPTH_BITS:0]        count_q, cnt_nxt;
  logic                       empty_q, full_q, rd_fire;
  logic [31:0]                drop_cnt_q, pkt_cnt_q;

  always_comb begin
    dv      = '0;
    qid_dec = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      dv[q] = s_axis_tuser[DST_PORT_POS + 2*q];
      if (dv[q]) qid_dec = NUM_QUEUES_BITS'(q);
    end
    dst_ok = $onehot(dv);
  end

  assign tuser_ext = DW'(s_axis_tuser);

  always_comb begin
    data_word = '0;
    hdr_word  = '0;
    for (int i = 0; i < NB; i++) begin
      data_word[9*i +: 9] = {s_axis_tstrb[i], s_axis_tdata[8*i +: 8]};
      hdr_word[9*i +: 9]  = {1'b0, tuser_ext[8*i +: 8]};
    end
  end

  always_comb begin
    state_nxt = state_q;
    tready_c  = 1'b0;
    wr_en     = 1'b0;
    wr_data   = data_word;
    wr_qid    = qid_q;
    wr_sof    = 1'b0;
    wr_eof    = s_axis_tlast;
    qid_ld    = 1'b0;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;
    case (state_q)
      S_HDR: begin
        if (s_axis_tvalid) begin
          if (!dst_ok) begin
            tready_c = 1'b1;
            if (s_axis_tlast) drop_inc = 1'b1;
            else              state_nxt = S_DROP;
          end else if (HDR_EN != 0) begin
            // header goes in first; the beat itself is taken from PKT
            if (!full_q) begin
              wr_en     = 1'b1;
              wr_data   = hdr_word;
              wr_qid    = qid_dec;
              wr_sof    = 1'b1;
              wr_eof    = 1'b0;
              qid_ld    = 1'b1;
              state_nxt = S_PKT;
            end
          end else begin
            tready_c = !full_q;
            wr_qid   = qid_dec;
            wr_sof   = 1'b1;
            if (!full_q) begin
              wr_en  = 1'b1;
              qid_ld = 1'b1;
              if (s_axis_tlast) pkt_inc = 1'b1;
              else              state_nxt = S_PKT;
            end
          end
        end
      end
      S_PKT: begin
        tready_c = !full_q;
        if (s_axis_tvalid && !full_q) begin
          wr_en = 1'b1;
          if (s_axis_tlast) begin
            pkt_inc   = 1'b1;
            state_nxt = S_HDR;
          end
        end
      end
      S_DROP: begin
        tready_c = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          drop_inc  = 1'b1;
          state_nxt = S_HDR;
        end
      end
      default: state_nxt = S_HDR;
    endcase
  end

  assign s_axis_tready = tready_c & ~sw_rst & ~axi_areset;
  assign rd_fire       = fifo_rd_en & ~empty_q;

  always_comb begin
    case ({wr_en, rd_fire})
      2'b10:   cnt_nxt = count_q + CNT_ONE;
      2'b01:   cnt_nxt = count_q - CNT_ONE;
      default: cnt_nxt = count_q;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q    <= S_HDR;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      qid_q      <= '0;
      drop_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else if (sw_rst) begin
      state_q    <= S_HDR;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      qid_q      <= '0;
      drop_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q <= state_nxt;
      if (wr_en)   wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
      count_q <= cnt_nxt;
      empty_q <= (cnt_nxt == '0);
      full_q  <= (cnt_nxt == CNT_FULL);
      if (qid_ld)  qid_q <= qid_dec;
      if (pkt_inc) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (drop_inc && (drop_cnt_q != 32'hFFFF_FFFF)) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  // storage needs no reset: contents are don't-care while empty
  always_ff @(posedge axi_aclk) begin
    if (wr_en) mem[wr_ptr] <= {wr_qid, wr_sof, wr_eof, wr_data};
  end

  assign {fifo_dout_qid, fifo_dout_sof, fifo_dout_eof, fifo_dout} = mem[rd_ptr];
  assign fifo_empty = empty_q;
  assign fifo_count = count_q;
  assign drop_cnt   = drop_cnt_q;
  assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_axis_to_qfifo.sv
// Scoreboard bench for axis_to_qfifo: a header-mode instance with a 4-deep FIFO
// and a data-only instance, sharing stimulus and selected by sel.
module tb_axis_to_qfifo;

  typedef struct packed {
    logic [287:0] w;
    logic [1:0]   qid;
    logic         sof;
    logic         eof;
  } exp_t;

  logic         clk = 1'b0;
  logic         areset, sw_rst;
  logic [255:0] tdata;
  logic [31:0]  tstrb;
  logic [127:0] tuser;
  logic         tvalid, tlast, rd_en;
  int           sel;
  bit           rd_on;

  logic         tvalid_a, tready_a, rd_a, sof_a, eof_a, empty_a;
  logic [287:0] dout_a;
  logic [1:0]   qid_a;
  logic [2:0]   cnt_a;
  logic [31:0]  drop_a, pkt_a;
  logic         tvalid_b, tready_b, rd_b, sof_b, eof_b, empty_b;
  logic [287:0] dout_b;
  logic [1:0]   qid_b;
  logic [4:0]   cnt_b;
  logic [31:0]  drop_b, pkt_b;

  logic         m_tready, m_sof, m_eof, m_empty;
  logic [287:0] m_dout;
  logic [1:0]   m_qid;
  logic [7:0]   m_cnt;
  logic [31:0]  m_drop, m_pkt;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  assign tvalid_a = tvalid && (sel == 0);
  assign tvalid_b = tvalid && (sel == 1);
  assign rd_a     = rd_en && (sel == 0);
  assign rd_b     = rd_en && (sel == 1);

  assign m_tready = (sel == 0) ? tready_a : tready_b;
  assign m_sof    = (sel == 0) ? sof_a    : sof_b;
  assign m_eof    = (sel == 0) ? eof_a    : eof_b;
  assign m_empty  = (sel == 0) ? empty_a  : empty_b;
  assign m_dout   = (sel == 0) ? dout_a   : dout_b;
  assign m_qid    = (sel == 0) ? qid_a    : qid_b;
  assign m_cnt    = (sel == 0) ? 8'(cnt_a) : 8'(cnt_b);
  assign m_drop   = (sel == 0) ? drop_a   : drop_b;
  assign m_pkt    = (sel == 0) ? pkt_a    : pkt_b;

  axis_to_qfifo #(.DEPTH_BITS(2), .HDR_EN(1)) u_dut_a (
    .axi_aclk(clk), .axi_areset(areset), .sw_rst(sw_rst),
    .s_axis_tdata(tdata), .s_axis_tstrb(tstrb), .s_axis_tuser(tuser),
    .s_axis_tvalid(tvalid_a), .s_axis_tready(tready_a), .s_axis_tlast(tlast),
    .fifo_rd_en(rd_a), .fifo_dout(dout_a), .fifo_dout_qid(qid_a),
    .fifo_dout_sof(sof_a), .fifo_dout_eof(eof_a), .fifo_empty(empty_a),
    .fifo_count(cnt_a), .drop_cnt(drop_a), .pkt_cnt(pkt_a));

  axis_to_qfifo #(.DEPTH_BITS(4), .HDR_EN(0)) u_dut_b (
    .axi_aclk(clk), .axi_areset(areset), .sw_rst(sw_rst),
    .s_axis_tdata(tdata), .s_axis_tstrb(tstrb), .s_axis_tuser(tuser),
    .s_axis_tvalid(tvalid_b), .s_axis_tready(tready_b), .s_axis_tlast(tlast),
    .fifo_rd_en(rd_b), .fifo_dout(dout_b), .fifo_dout_qid(qid_b),
    .fifo_dout_sof(sof_b), .fifo_dout_eof(eof_b), .fifo_empty(empty_b),
    .fifo_count(cnt_b), .drop_cnt(drop_b), .pkt_cnt(pkt_b));

  task automatic chk(input string tag, input logic [287:0] act, input logic [287:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [287:0] pack_data(input logic [255:0] d, input logic [31:0] s);
    logic [287:0] w;
    for (int i = 0; i < 32; i++) w[9*i +: 9] = {s[i], d[8*i +: 8]};
    return w;
  endfunction

  function automatic logic [287:0] pack_hdr(input logic [127:0] u);
    logic [287:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) w[9*i +: 9] = {1'b0, u[8*i +: 8]};
    return w;
  endfunction

  // random TUSER with destination flags cleared, then the requested ones set
  function automatic logic [127:0] mk_tuser(input logic [3:0] flags);
    logic [127:0] u;
    u = {$urandom, $urandom, $urandom, $urandom};
    for (int q = 0; q < 4; q++) u[24 + 2*q] = flags[q];
    return u;
  endfunction

  task automatic send_pkt(input logic [127:0] tu, input int nb, input logic [31:0] last_strb,
                          input bit valid, input logic [1:0] qid, input int stop_after);
    exp_t e;
    int   n;
    bit   hdr;
    hdr = (sel == 0);
    for (int b = 0; b < nb && b < stop_after; b++) begin
      @(negedge clk);
      tvalid = 1'b1;
      tuser  = tu;
      tdata  = rand256();
      tstrb  = (b == nb - 1) ? last_strb : 32'hFFFF_FFFF;
      tlast  = (b == nb - 1);
      if (b == 0 && valid && hdr) begin
        e.w = pack_hdr(tu); e.qid = qid; e.sof = 1'b1; e.eof = 1'b0;
        exp_q.push_back(e);
      end
      #1;
      if (!valid) chk("drop_tready", m_tready, 1);
      n = 0;
      while (!m_tready && n < 200) begin
        @(negedge clk); #1; n++;
      end
      if (!m_tready) begin
        chk("tready_timeout", m_tready, 1);
        break;
      end
      if (valid) begin
        e.w = pack_data(tdata, tstrb); e.qid = qid;
        e.sof = (b == 0) && !hdr; e.eof = tlast;
        exp_q.push_back(e);
      end
      @(posedge clk);
    end
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !m_empty) && n < 300) begin
      @(negedge clk); n++;
    end
    chk("drain", (exp_q.size() != 0) || !m_empty, 0);
    rd_on = 0;
    @(negedge clk);
  endtask

  // reader: compares the head against the scoreboard and pops it
  initial begin
    exp_t e;
    rd_en = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_on && !m_empty) begin
        if (exp_q.size() == 0) chk("sb_size", 288'(exp_q.size()), 1);
        else begin
          e = exp_q.pop_front();
          chk("dout", m_dout, e.w);
          chk("qid", m_qid, e.qid);
          chk("sof", m_sof, e.sof);
          chk("eof", m_eof, e.eof);
        end
        rd_en = 1'b1;
      end else rd_en = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] tu;
    sel = 0; rd_on = 0;
    areset = 1'b1; sw_rst = 1'b0;
    tvalid = 1'b1; tlast = 1'b1; tdata = '0; tstrb = '1;
    tuser = mk_tuser(4'b0000);
    repeat (3) @(negedge clk);
    chk("rst_empty", m_empty, 1);
    chk("rst_count", m_cnt, 0);
    chk("rst_tready", m_tready, 0);
    chk("rst_drop", m_drop, 0);
    chk("rst_pkt", m_pkt, 0);
    tvalid = 1'b0; tlast = 1'b0;
    areset = 1'b0;
    @(negedge clk);

    // 3-beat packet to queue 2 fills the 4-deep FIFO exactly
    send_pkt(mk_tuser(4'b0100), 3, 32'h0000_FFFF, 1, 2'd2, 99);
    chk("a_count", m_cnt, 4);
    chk("a_pkt", m_pkt, 1);
    rd_on = 1;
    wait_drain();

    // multi-hot destination, then no destination: both dropped
    send_pkt(mk_tuser(4'b0011), 5, 32'hFFFF_FFFF, 0, 2'd0, 99);
    chk("mh_count", m_cnt, 0);
    chk("mh_drop", m_drop, 1);
    send_pkt(mk_tuser(4'b0000), 1, 32'hFFFF_FFFF, 0, 2'd0, 99);
    chk("none_drop", m_drop, 2);
    send_pkt(mk_tuser(4'b0001), 2, 32'h8000_0001, 1, 2'd0, 99);
    rd_on = 1;
    wait_drain();
    chk("mh_pkt", m_pkt, 2);

    // 10-beat packet with reads held off, then one read per cycle
    fork
      send_pkt(mk_tuser(4'b1000), 10, 32'h0000_0003, 1, 2'd3, 99);
      begin
        repeat (8) @(negedge clk);
        #2;
        chk("full_count", m_cnt, 4);
        chk("full_tready", m_tready, 0);
        rd_on = 1;
      end
    join
    wait_drain();
    chk("full_pkt", m_pkt, 3);

    // data-only instance
    sel = 1;
    @(negedge clk);
    chk("h0_empty_pre", m_empty, 1);
    send_pkt(mk_tuser(4'b0010), 1, 32'h0000_00FF, 1, 2'd1, 99);
    chk("h0_empty_post", m_empty, 0);
    chk("h0_count", m_cnt, 1);
    rd_on = 1;
    wait_drain();
    send_pkt(mk_tuser(4'b1000), 3, 32'h0000_0001, 1, 2'd3, 99);
    rd_on = 1;
    wait_drain();
    chk("h0_pkt", m_pkt, 2);

    // synchronous clear with words pending
    sel = 0;
    send_pkt(mk_tuser(4'b0001), 1, 32'hFFFF_FFFF, 1, 2'd0, 99);
    chk("sw_pre_count", m_cnt, 2);
    sw_rst = 1'b1;
    @(negedge clk);
    sw_rst = 1'b0;
    exp_q.delete();
    chk("sw_empty", m_empty, 1);
    chk("sw_count", m_cnt, 0);
    chk("sw_pkt", m_pkt, 0);
    chk("sw_drop", m_drop, 0);

    // build up counters, then async reset in the middle of a packet
    send_pkt(mk_tuser(4'b0010), 1, 32'hFFFF_FFFF, 1, 2'd1, 99);
    send_pkt(mk_tuser(4'b0000), 1, 32'hFFFF_FFFF, 0, 2'd0, 99);
    rd_on = 1;
    wait_drain();
    chk("ar_pre_pkt", m_pkt, 1);
    chk("ar_pre_drop", m_drop, 1);
    send_pkt(mk_tuser(4'b0100), 4, 32'hFFFF_FFFF, 1, 2'd2, 2);
    #2;
    areset = 1'b1;
    #1;
    chk("ar_empty", m_empty, 1);
    chk("ar_count", m_cnt, 0);
    chk("ar_pkt", m_pkt, 0);
    chk("ar_drop", m_drop, 0);
    tvalid = 1'b1;
    tuser  = mk_tuser(4'b0000);
    #1;
    chk("ar_tready", m_tready, 0);
    tvalid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    send_pkt(mk_tuser(4'b0010), 2, 32'h0000_0F0F, 1, 2'd1, 99);
    rd_on = 1;
    wait_drain();
    chk("ar_post_pkt", m_pkt, 1);

    // drop counter saturation
    @(negedge clk);
    force u_dut_a.drop_cnt_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release u_dut_a.drop_cnt_q;
    @(negedge clk);
    chk("sat_forced", m_drop, 32'hFFFF_FFFE);
    send_pkt(mk_tuser(4'b0101), 2, 32'hFFFF_FFFF, 0, 2'd0, 99);
    chk("sat_max", m_drop, 32'hFFFF_FFFF);
    send_pkt(mk_tuser(4'b0000), 1, 32'hFFFF_FFFF, 0, 2'd0, 99);
    chk("sat_hold", m_drop, 32'hFFFF_FFFF);
    chk("sat_empty", m_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
